// File: rtl/snake_pkg.sv
// Shared encodings, colours and helpers for the snake engine and its cell comparator.
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] GS_PLAY      = 2'b01;
  localparam logic [1:0] GS_GAME_OVER = 2'b11;

  localparam logic [2:0] RGB_HEAD_DEFAULT = 3'b110;
  localparam logic [2:0] RGB_BODY_DEFAULT = 3'b010;
  localparam logic [2:0] RGB_OFF          = 3'b000;

  // Reverse of a heading; non-moving codes map to IDLE.
  function automatic logic [2:0] opposite(input logic [2:0] dir);
    logic [2:0] opp;
    case (dir)
      DIR_UP:    opp = DIR_DOWN;
      DIR_DOWN:  opp = DIR_UP;
      DIR_LEFT:  opp = DIR_RIGHT;
      DIR_RIGHT: opp = DIR_LEFT;
      default:   opp = DIR_IDLE;
    endcase
    return opp;
  endfunction

endpackage

// File: rtl/snake_cell_match.sv
// One cell of the snake: tests whether the current pixel lies inside the cell
// and whether the cell sits on the same grid position as a reference cell.
module snake_cell_match #(
  parameter int unsigned SIZE = 5,
  parameter int unsigned BIT  = 10
) (
  input  logic [BIT-1:0] cell_x,
  input  logic [BIT-1:0] cell_y,
  input  logic [BIT-1:0] x_pos,
  input  logic [BIT-1:0] y_pos,
  input  logic [BIT-1:0] ref_x,
  input  logic [BIT-1:0] ref_y,
  output logic           pixel_in_c,
  output logic           cell_eq_c
);

  localparam int unsigned EW = BIT + 1;

  logic [EW-1:0] x_end;
  logic [EW-1:0] y_end;

  // Extra bit on the far edge so cells touching the top of the range do not wrap.
  always_comb begin
    x_end      = EW'(cell_x) + EW'(SIZE);
    y_end      = EW'(cell_y) + EW'(SIZE);
    pixel_in_c = (x_pos >= cell_x) && (EW'(x_pos) < x_end) &&
                 (y_pos >= cell_y) && (EW'(y_pos) < y_end);
    cell_eq_c  = (cell_x == ref_x) && (cell_y == ref_y);
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake head plus MAX_LEN body segments: stepping, growth, reversal rejection,
// wall/self collision via a sequential body scan, and per-pixel rendering.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int unsigned SIZE      = 5,
  parameter int unsigned BIT       = 10,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned START_LEN = 2,
  parameter int unsigned X_START   = 320,
  parameter int unsigned Y_START   = 240,
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter bit          WRAP      = 1'b0,
  parameter logic [2:0]  HEAD_RGB  = RGB_HEAD_DEFAULT,
  parameter logic [2:0]  BODY_RGB  = RGB_BODY_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           update,
  input  logic [2:0]                     direction,
  input  logic [1:0]                     game_state,
  input  logic                           grow,
  input  logic [BIT-1:0]                 x_pos,
  input  logic [BIT-1:0]                 y_pos,
  output logic                           snake_head_active,
  output logic                           snake_body_active,
  output logic [2:0]                     rgb,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic                           self_hit,
  output logic                           wall_hit,
  output logic                           step_done
);

  localparam int unsigned LW    = $clog2(MAX_LEN + 1);
  localparam int unsigned NSEG  = MAX_LEN + 1;
  localparam logic [BIT-1:0] STEP  = BIT'(SIZE);
  localparam logic [BIT-1:0] X_MAX = BIT'(H_RES - SIZE);
  localparam logic [BIT-1:0] Y_MAX = BIT'(V_RES - SIZE);

  // Index 0 is the head, 1..MAX_LEN are body[0..MAX_LEN-1].
  logic [BIT-1:0] seg_x [NSEG];
  logic [BIT-1:0] seg_y [NSEG];

  state_e         state;
  state_e         state_nxt;
  logic [2:0]     heading;
  logic [2:0]     heading_nxt;
  logic [2:0]     new_heading;
  logic           grow_pending;
  logic [LW-1:0]  idx;
  logic [LW-1:0]  idx_nxt;
  logic [LW-1:0]  scan_sel;
  logic           game_over;
  logic           dir_ok;
  logic [BIT-1:0] nx;
  logic [BIT-1:0] ny;
  logic [BIT-1:0] move_x;
  logic [BIT-1:0] move_y;
  logic           oor;
  logic           do_shift;
  logic           do_wall;
  logic           scan_hit;
  logic           step_nxt;
  logic [NSEG-1:0] in_cell;
  logic [NSEG-1:0] eq_head;
  logic [NSEG-1:0] seg_valid;

  assign game_over = (game_state == GS_GAME_OVER);
  assign scan_sel  = idx + LW'(1);

  // Candidate heading and next head position, with optional toroidal wrap.
  always_comb begin
    dir_ok = (direction == DIR_UP) || (direction == DIR_DOWN) ||
             (direction == DIR_LEFT) || (direction == DIR_RIGHT);
    new_heading = (dir_ok && (direction != opposite(heading))) ? direction : heading;
    nx = seg_x[0];
    ny = seg_y[0];
    case (new_heading)
      DIR_UP:    ny = seg_y[0] - STEP;
      DIR_DOWN:  ny = seg_y[0] + STEP;
      DIR_LEFT:  nx = seg_x[0] - STEP;
      DIR_RIGHT: nx = seg_x[0] + STEP;
      default:   ;
    endcase
    oor    = (nx > X_MAX) || (ny > Y_MAX);
    move_x = nx;
    move_y = ny;
    if (nx > X_MAX) move_x = (new_heading == DIR_LEFT) ? X_MAX : '0;
    if (ny > Y_MAX) move_y = (new_heading == DIR_UP)   ? Y_MAX : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    heading_nxt = heading;
    idx_nxt     = idx;
    do_shift    = 1'b0;
    do_wall     = 1'b0;
    scan_hit    = 1'b0;
    step_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (update && (game_state == GS_PLAY) && !self_hit && !wall_hit)
          state_nxt = ST_MOVE;
      end
      ST_MOVE: begin
        heading_nxt = new_heading;
        if (oor && !WRAP) begin
          do_wall   = 1'b1;
          step_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          do_shift  = 1'b1;
          idx_nxt   = '0;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        scan_hit = eq_head[scan_sel];
        idx_nxt  = idx + LW'(1);
        if (idx == length - LW'(1)) begin
          step_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (game_over) begin
      state_nxt = ST_IDLE;
      step_nxt  = 1'b0;
    end
  end

  // Segment registers, growth, sticky flags; GAME_OVER reloads the start layout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NSEG; i++) begin
        seg_x[i] <= BIT'(X_START - i * SIZE);
        seg_y[i] <= BIT'(Y_START);
      end
      heading      <= DIR_RIGHT;
      length       <= LW'(START_LEN);
      grow_pending <= 1'b0;
      self_hit     <= 1'b0;
      wall_hit     <= 1'b0;
      step_done    <= 1'b0;
      idx          <= '0;
    end else if (game_over) begin
      for (int unsigned i = 0; i < NSEG; i++) begin
        seg_x[i] <= BIT'(X_START - i * SIZE);
        seg_y[i] <= BIT'(Y_START);
      end
      heading      <= DIR_RIGHT;
      length       <= LW'(START_LEN);
      grow_pending <= 1'b0;
      self_hit     <= 1'b0;
      wall_hit     <= 1'b0;
      step_done    <= 1'b0;
      idx          <= '0;
    end else begin
      heading      <= heading_nxt;
      idx          <= idx_nxt;
      grow_pending <= grow | (grow_pending & ~do_shift);
      self_hit     <= self_hit | scan_hit;
      wall_hit     <= wall_hit | do_wall;
      step_done    <= step_nxt;
      if (do_shift) begin
        seg_x[0] <= move_x;
        seg_y[0] <= move_y;
        for (int unsigned i = 1; i < NSEG; i++) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        if (grow_pending && (length < LW'(MAX_LEN)))
          length <= length + LW'(1);
      end
    end
  end

  for (genvar g = 0; g < NSEG; g++) begin : g_cell
    snake_cell_match #(
      .SIZE (SIZE),
      .BIT  (BIT)
    ) u_match (
      .cell_x     (seg_x[g]),
      .cell_y     (seg_y[g]),
      .x_pos      (x_pos),
      .y_pos      (y_pos),
      .ref_x      (seg_x[0]),
      .ref_y      (seg_y[0]),
      .pixel_in_c (in_cell[g]),
      .cell_eq_c  (eq_head[g])
    );
  end

  // Only the first `length` body segments render.
  always_comb begin
    seg_valid = '0;
    for (int unsigned i = 1; i < NSEG; i++)
      seg_valid[i] = (LW'(i) <= length);
    snake_head_active = in_cell[0];
    snake_body_active = |(in_cell & seg_valid);
    if (snake_head_active)      rgb = HEAD_RGB;
    else if (snake_body_active) rgb = BODY_RGB;
    else                        rgb = RGB_OFF;
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Scoreboard bench for snake_body_engine: stimulus queues expected step results,
// per-instance monitors check them when step_done fires.
module tb_snake_body_engine;
  import snake_pkg::*;

  typedef struct {
    int len;
    int self_hit;
    int wall_hit;
    int head;
    int lat;
    int t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] direction;
  logic [1:0] game_state;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] upd;
  logic [2:0] grw;
  logic [2:0] hd, bd, sd, sh, wh;
  logic [2:0] rgb_m, rgb_w, rgb_s;
  logic [4:0] len_m, len_w;
  logic [2:0] len_s;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   sd_seen [3];
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e0, e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snake_body_engine dut_m (
    .clk(clk), .reset(reset), .update(upd[0]), .direction(direction),
    .game_state(game_state), .grow(grw[0]), .x_pos(x_pos), .y_pos(y_pos),
    .snake_head_active(hd[0]), .snake_body_active(bd[0]), .rgb(rgb_m),
    .length(len_m), .self_hit(sh[0]), .wall_hit(wh[0]), .step_done(sd[0]));

  snake_body_engine #(.WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .update(upd[1]), .direction(direction),
    .game_state(game_state), .grow(grw[1]), .x_pos(x_pos), .y_pos(y_pos),
    .snake_head_active(hd[1]), .snake_body_active(bd[1]), .rgb(rgb_w),
    .length(len_w), .self_hit(sh[1]), .wall_hit(wh[1]), .step_done(sd[1]));

  snake_body_engine #(.MAX_LEN(4), .START_LEN(3)) dut_s (
    .clk(clk), .reset(reset), .update(upd[2]), .direction(direction),
    .game_state(game_state), .grow(grw[2]), .x_pos(x_pos), .y_pos(y_pos),
    .snake_head_active(hd[2]), .snake_body_active(bd[2]), .rgb(rgb_s),
    .length(len_s), .self_hit(sh[2]), .wall_hit(wh[2]), .step_done(sd[2]));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_step(input string nm, input exp_t e, input int len,
                            input int s, input int w, input int h);
    chk({nm, " latency"},     cyc - e.t0, e.lat);
    chk({nm, " length"},      len, e.len);
    chk({nm, " self_hit"},    s, e.self_hit);
    chk({nm, " wall_hit"},    w, e.wall_hit);
    chk({nm, " head_active"}, h, e.head);
  endtask

  always @(negedge clk) if (sd[0]) begin
    sd_seen[0]++;
    if (q0.size() == 0) chk("main unexpected step_done", 1, 0);
    else begin
      e0 = q0.pop_front();
      check_step("main", e0, int'(len_m), int'(sh[0]), int'(wh[0]), int'(hd[0]));
    end
  end

  always @(negedge clk) if (sd[1]) begin
    sd_seen[1]++;
    if (q1.size() == 0) chk("wrap unexpected step_done", 1, 0);
    else begin
      e1 = q1.pop_front();
      check_step("wrap", e1, int'(len_w), int'(sh[1]), int'(wh[1]), int'(hd[1]));
    end
  end

  always @(negedge clk) if (sd[2]) begin
    sd_seen[2]++;
    if (q2.size() == 0) chk("sat unexpected step_done", 1, 0);
    else begin
      e2 = q2.pop_front();
      check_step("sat", e2, int'(len_s), int'(sh[2]), int'(wh[2]), int'(hd[2]));
    end
  end

  task automatic push(input int inst, input int len, input int s, input int w,
                      input int h, input int lat);
    exp_t e;
    e.len = len; e.self_hit = s; e.wall_hit = w; e.head = h; e.lat = lat; e.t0 = cyc;
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic probe(input int x, input int y);
    x_pos = 10'(x);
    y_pos = 10'(y);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      chk("step_timeout pending", q0.size() + q1.size() + q2.size(), 0);
      q0.delete(); q1.delete(); q2.delete();
    end
    @(negedge clk);
  endtask

  // Update pulse for the masked instances; grow_mid lands grow on the MOVE cycle.
  task automatic step(input logic [2:0] dir, input logic [2:0] mask, input bit grow_mid);
    direction = dir;
    upd = mask;
    @(negedge clk);
    upd = '0;
    if (grow_mid) grw = mask;
    @(negedge clk);
    grw = '0;
    wait_drain();
  endtask

  task automatic pulse_grow(input logic [2:0] mask);
    grw = mask;
    @(negedge clk);
    grw = '0;
    @(negedge clk);
  endtask

  task automatic ignored_update(input logic [2:0] mask);
    int n;
    n = sd_seen[0];
    upd = mask;
    @(negedge clk);
    upd = '0;
    repeat (10) @(negedge clk);
    chk("ignored update step_done count", sd_seen[0] - n, 0);
  endtask

  task automatic game_over_pulse();
    game_state = GS_GAME_OVER;
    repeat (2) @(negedge clk);
    game_state = GS_PLAY;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    sd_seen[0] = 0; sd_seen[1] = 0; sd_seen[2] = 0;
    reset = 1'b0; upd = '0; grw = '0; direction = DIR_IDLE;
    game_state = 2'b00; x_pos = '0; y_pos = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    chk("reset length", int'(len_m), 2);
    chk("reset self_hit", int'(sh[0]), 0);
    chk("reset wall_hit", int'(wh[0]), 0);
    chk("reset step_done", int'(sd[0]), 0);
    chk("reset sat length", int'(len_s), 3);
    probe(320, 240); chk("reset head at start", int'(hd[0]), 1);
    chk("reset head rgb", int'(rgb_m), 6);
    probe(324, 244); chk("head far corner inside", int'(hd[0]), 1);
    probe(325, 240); chk("head right edge exclusive", int'(hd[0]), 0);
    chk("empty pixel body", int'(bd[0]), 0);
    chk("empty pixel rgb", int'(rgb_m), 0);
    probe(315, 240); chk("reset body0", int'(bd[0]), 1);
    chk("body rgb", int'(rgb_m), 2);
    probe(310, 244); chk("reset body1", int'(bd[0]), 1);
    probe(305, 240); chk("segment beyond length hidden", int'(bd[0]), 0);
    chk("sat third segment visible", int'(bd[2]), 1);

    game_state = GS_PLAY;
    @(negedge clk);

    // Basic moves, reversal rejection, growth with grow during the shift.
    probe(325, 240); push(0, 2, 0, 0, 1, 4); step(DIR_RIGHT, 3'b001, 1'b0);
    probe(320, 240); chk("body0 is old head", int'(bd[0]), 1);
    probe(310, 240); chk("tail vacated", int'(bd[0]), 0);
    probe(330, 240); push(0, 2, 0, 0, 1, 4); step(DIR_LEFT, 3'b001, 1'b0);
    pulse_grow(3'b001);
    probe(335, 240); push(0, 3, 0, 0, 1, 5); step(DIR_RIGHT, 3'b001, 1'b1);
    probe(340, 240); push(0, 4, 0, 0, 1, 6); step(DIR_RIGHT, 3'b001, 1'b0);
    probe(345, 240); push(0, 4, 0, 0, 1, 6); step(DIR_RIGHT, 3'b001, 1'b0);
    probe(325, 240); chk("len4 tail visible", int'(bd[0]), 1);
    probe(320, 244); chk("len4 fifth segment hidden", int'(bd[0]), 0);
    pulse_grow(3'b001);
    probe(350, 240); push(0, 5, 0, 0, 1, 7); step(DIR_RIGHT, 3'b001, 1'b0);
    probe(350, 235); push(0, 5, 0, 0, 1, 7); step(DIR_UP, 3'b001, 1'b0);
    probe(345, 235); push(0, 5, 0, 0, 1, 7); step(DIR_LEFT, 3'b001, 1'b0);
    probe(345, 240); push(0, 5, 1, 0, 1, 7); step(DIR_DOWN, 3'b001, 1'b0);
    chk("self hit rgb is head", int'(rgb_m), 6);
    ignored_update(3'b001);
    chk("self_hit sticky", int'(sh[0]), 1);
    game_over_pulse();
    chk("game over clears self_hit", int'(sh[0]), 0);
    chk("game over length", int'(len_m), 2);
    probe(320, 240); chk("game over head start", int'(hd[0]), 1);
    probe(345, 240); chk("game over old head gone", int'(hd[0]), 0);

    // March to the top edge: wall stop for WRAP=0, wrap-around for WRAP=1.
    for (int k = 1; k <= 48; k++) begin
      probe(320, 240 - 5 * k);
      push(0, 2, 0, 0, 1, 4);
      push(1, 2, 0, 0, 1, 4);
      step(DIR_UP, 3'b011, 1'b0);
    end
    probe(320, 0);
    push(0, 2, 0, 1, 1, 2);
    push(1, 2, 0, 0, 0, 4);
    step(DIR_UP, 3'b011, 1'b0);
    probe(320, 475); chk("wrap head at bottom", int'(hd[1]), 1);
    chk("wall head not moved down", int'(hd[0]), 0);
    probe(320, 5); chk("wall body unchanged", int'(bd[0]), 1);
    ignored_update(3'b001);
    probe(320, 0); chk("wall head still at top", int'(hd[0]), 1);
    chk("wall_hit sticky", int'(wh[0]), 1);
    game_over_pulse();
    chk("game over clears wall_hit", int'(wh[0]), 0);
    probe(320, 240); chk("wall restart head", int'(hd[0]), 1);

    // Saturating growth on the MAX_LEN=4 instance.
    pulse_grow(3'b100);
    probe(325, 240); push(2, 4, 0, 0, 1, 6); step(DIR_RIGHT, 3'b100, 1'b1);
    probe(330, 240); push(2, 4, 0, 0, 1, 6); step(DIR_RIGHT, 3'b100, 1'b0);
    probe(335, 240); push(2, 4, 0, 0, 1, 6); step(DIR_RIGHT, 3'b100, 1'b0);
    probe(315, 240); chk("sat tail segment", int'(bd[2]), 1);
    probe(310, 240); chk("sat beyond capacity", int'(bd[2]), 0);

    // Reset in the middle of a scan.
    probe(325, 240); push(0, 2, 0, 0, 1, 4); step(DIR_RIGHT, 3'b001, 1'b0);
    direction = DIR_RIGHT;
    upd = 3'b001;
    @(negedge clk);
    upd = '0;
    repeat (2) @(negedge clk);
    n = sd_seen[0];
    reset = 1'b0;
    probe(320, 240); chk("mid-scan reset head start", int'(hd[0]), 1);
    probe(325, 240); chk("mid-scan reset old head gone", int'(hd[0]), 0);
    chk("mid-scan reset length", int'(len_m), 2);
    chk("mid-scan reset step_done", int'(sd[0]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("no step_done after reset", sd_seen[0] - n, 0);
    chk("no scoreboard leftovers", q0.size() + q1.size() + q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Parametrised snake engine replacing the fixed two-segment snake renderer. It holds a head plus up to MAX_LEN body segments and moves them one cell per `update` tick. It grows on `grow` requests, rejects 180° reversals, and detects wall and self collisions with a sequential body scan. It sits between the game-state controller (consumes `self_hit`/`wall_hit`/`step_done`) and the pixel mux (consumes `*_active`/`rgb`).

## Interface
- SIZE, 5: cell edge in pixels; every step moves the head by SIZE.
- BIT, 10: coordinate width.
- MAX_LEN, 16: body segment capacity (≥2).
- START_LEN, 2: body length after reset/GAME_OVER (1..MAX_LEN).
- X_START, 320 / Y_START, 240: head start cell (top-left pixel).
- H_RES, 640 / V_RES, 480: playfield size in pixels.
- WRAP, 0: 0 = wall collision; 1 = toroidal wrap.
- HEAD_RGB, 3'b110 / BODY_RGB, 3'b010: colours.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- update  in  1  step tick; sampled only in IDLE.
- direction  in  3  IDLE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4.
- game_state  in  2  PLAY=2'b01, GAME_OVER=2'b11.
- grow  in  1  one-cycle grow request, any state.
- x_pos, y_pos  in  BIT  current pixel.
- snake_head_active, snake_body_active  out  1  pixel inside head / any valid segment.
- rgb  out  3  HEAD_RGB if head, else BODY_RGB if body, else 0.
- length  out  $clog2(MAX_LEN+1)  valid body segments.
- self_hit, wall_hit  out  1  sticky collision flags.
- step_done  out  1  one-cycle pulse at end of each accepted step.

## Operation
- Reset (async) and GAME_OVER (sync, every cycle while asserted, overrides everything): head=(X_START,Y_START); body[i]=(X_START-(i+1)*SIZE, Y_START); heading=RIGHT; length=START_LEN; grow_pending=0; flags=0; FSM=IDLE; step_done=0.
- FSM: IDLE → MOVE when update && game_state==PLAY && !self_hit && !wall_hit. Otherwise stay IDLE. update outside IDLE is dropped.
- MOVE, heading update: direction IDLE or opposite of heading keeps the heading; otherwise heading=direction.
- MOVE, next head: head ± SIZE on the heading axis, computed at BIT width. Underflow wraps to a large value, so it counts as out of range.
- Out of range means x > H_RES-SIZE or y > V_RES-SIZE.
- WRAP=0 and out of range: wall_hit=1, no shift, go to DONE.
- WRAP=1: UP at y=0 → V_RES-SIZE; DOWN past edge → 0; same rule on the X axis.
- Otherwise: body[j]=body[j-1] for j≥1, body[0]=old head, head=next head.
- Growth: grow_pending is set by a grow pulse and cleared when a shift consumes it. On that shift, length=min(length+1, MAX_LEN). A grow and a consuming shift in the same cycle leaves grow_pending set.
- MOVE → SCAN with idx=0.
- SCAN: each cycle compare body[idx] to head; equality sets self_hit. idx increments; after idx=length-1 go to DONE. The scan always runs the full length.
- DONE: step_done=1 for one cycle, then IDLE.
- Rendering is combinational. The cell test is x_pos∈[X,X+SIZE) and y_pos∈[Y,Y+SIZE). Segments with i≥length never drive `*_active`.

## Timing
- update sampled at edge E0 → MOVE. Registers shift at E1. SCAN runs E2..E(1+L), where L = length after the shift. step_done is high in the cycle after E(1+L).
- Step latency from update to step_done is L+2 cycles. Worst case is MAX_LEN+2, which must be less than the update period.
- Wall hit: step_done in the cycle after E1.
- self_hit/wall_hit are valid when step_done is high and hold until reset or GAME_OVER.
- Outputs `*_active` and rgb follow the registered positions with zero latency.

## Structure
- Shared package `snake_pkg`: direction encodings, game_state encodings, colour constants, and an `opposite(dir)` function.
- Sub-module `snake_cell_match` (pixel-in-cell and cell-equality compare), instantiated once per segment plus once for the head.
- Remaining logic (FSM, segment registers, scan counter) lives in the top module.

## Test plan
- Reset then deassert; PLAY; RIGHT; one update → head (325,240), body[0]=(320,240), length 2, step_done exactly 4 cycles after update.
- Heading RIGHT, direction=LEFT, update → head x+5 (reversal rejected); then UP → y-5.
- grow pulse then 3 updates with MAX_LEN=4, START_LEN=3 → length 4 after first step, stays 4 (saturation); grow coinciding with that shift → grow_pending still set.
- WRAP=0, head y=0, UP, update → wall_hit=1, positions unchanged; later updates ignored until GAME_OVER restores start state. WRAP=1 same stimulus → head y=475.
- Length 5: UP, LEFT, DOWN steps → self_hit=1 at step_done; GAME_OVER → flags clear, length=START_LEN.
- Assert reset mid-SCAN → immediate return to reset values, step_done never pulses.
